// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Owns the program counter of the single-cycle core. It issues fetch
// addresses to the instruction cache, supplies PC+4 to the target adder and
// applies resolved branch/jump targets. The PC freezes while either cache is
// busy. A redirect that resolves during a data stall is buffered and applied
// when the stall releases.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INSTR_BUSYWAIT,
  input  logic             DATA_BUSYWAIT,
  input  logic             REDIRECT_VALID,
  input  logic [31:0]      REDIRECT_TARGET,
  output logic [31:0]      PC,
  output logic [31:0]      NEXT4PC,
  output logic             FETCH_READ,
  output logic             ALIGN_ERR,
  output logic [CNT_W-1:0] STALL_COUNT
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               fetch_read_q, fetch_read_d;
  logic               pend_valid_q, pend_valid_d;
  logic [31:0]        pend_target_q, pend_target_d;
  logic               align_err_q, align_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               stall;
  logic [31:0]        next4;
  logic [31:0]        live_target;
  logic [31:0]        live_next;
  logic               target_misaligned;
  // A redirect is only meaningful when the instruction itself is valid;
  // it is captured for later when the data side is what holds us up.
  logic               latch_redirect;

  assign stall             = INSTR_BUSYWAIT | DATA_BUSYWAIT;
  assign next4             = pc_q + 32'd4;
  assign live_target       = {REDIRECT_TARGET[31:2], 2'b00};
  assign live_next         = REDIRECT_VALID ? live_target : next4;
  assign target_misaligned = (REDIRECT_TARGET[1:0] != 2'b00);
  assign latch_redirect    = REDIRECT_VALID & ~INSTR_BUSYWAIT & DATA_BUSYWAIT;

  // Next-state and next-output computation for the fetch sequencer.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    align_err_d   = align_err_q;
    stall_cnt_d   = stall_cnt_q;

    case (state_q)
      ST_BOOT: begin
        // One settling cycle after reset; busywait is deliberately ignored.
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (!stall) begin
          pc_d = live_next;
          if (REDIRECT_VALID && target_misaligned) begin
            align_err_d = 1'b1;
          end
        end else begin
          state_d = ST_STALL;
          if (latch_redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = live_target;
            if (target_misaligned) begin
              align_err_d = 1'b1;
            end
          end
        end
      end

      ST_STALL: begin
        if (stall) begin
          // Keep the most recent redirect seen while only data is stalled.
          if (latch_redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = live_target;
            if (target_misaligned) begin
              align_err_d = 1'b1;
            end
          end
        end else begin
          // A buffered redirect outranks whatever is presented on release.
          if (pend_valid_q) begin
            pc_d = pend_target_q;
          end else begin
            pc_d = live_next;
            if (REDIRECT_VALID && target_misaligned) begin
              align_err_d = 1'b1;
            end
          end
          pend_valid_d = 1'b0;
          state_d      = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Saturating stall-cycle counter; BOOT cycles never count.
    if ((state_q != ST_BOOT) && stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Fetch request is a registered function of the upcoming state.
    fetch_read_d = (state_d != ST_BOOT);
  end

  // State register with synchronous reset; reset discards any pending redirect.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fetch_read_q  <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'd0;
      align_err_q   <= 1'b0;
      stall_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_read_q  <= fetch_read_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      align_err_q   <= align_err_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign PC          = pc_q;
  assign NEXT4PC     = next4;
  assign FETCH_READ  = fetch_read_q;
  assign ALIGN_ERR   = align_err_q;
  assign STALL_COUNT = stall_cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed testbench for pc_fetch_sequencer.
module tb_pc_fetch_sequencer;

  logic        CLK;
  logic        RESET;
  logic        INSTR_BUSYWAIT;
  logic        DATA_BUSYWAIT;
  logic        REDIRECT_VALID;
  logic [31:0] REDIRECT_TARGET;
  logic [31:0] PC;
  logic [31:0] NEXT4PC;
  logic        FETCH_READ;
  logic        ALIGN_ERR;
  logic [15:0] STALL_COUNT;

  int checks   = 0;
  int failures = 0;

  pc_fetch_sequencer #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (16)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .INSTR_BUSYWAIT (INSTR_BUSYWAIT),
    .DATA_BUSYWAIT  (DATA_BUSYWAIT),
    .REDIRECT_VALID (REDIRECT_VALID),
    .REDIRECT_TARGET(REDIRECT_TARGET),
    .PC             (PC),
    .NEXT4PC        (NEXT4PC),
    .FETCH_READ     (FETCH_READ),
    .ALIGN_ERR      (ALIGN_ERR),
    .STALL_COUNT    (STALL_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one posedge and settle; print one line per transaction.
  task automatic tick(input string what);
    @(posedge CLK);
    #1;
    $display("step %-12s rst=%b ib=%b db=%b rv=%b tgt=%h | pc=%h n4=%h fr=%b ae=%b sc=%0d",
             what, RESET, INSTR_BUSYWAIT, DATA_BUSYWAIT, REDIRECT_VALID,
             REDIRECT_TARGET, PC, NEXT4PC, FETCH_READ, ALIGN_ERR, STALL_COUNT);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the full visible state in one call.
  task automatic chk_all(input string tag, input logic [31:0] pc_e, input logic fr_e,
                         input logic ae_e, input logic [15:0] sc_e);
    chk({tag, ".pc"}, PC, pc_e);
    chk({tag, ".next4"}, NEXT4PC, pc_e + 32'd4);
    chk({tag, ".fetch_read"}, {31'd0, FETCH_READ}, {31'd0, fr_e});
    chk({tag, ".align_err"}, {31'd0, ALIGN_ERR}, {31'd0, ae_e});
    chk({tag, ".stall_count"}, {16'd0, STALL_COUNT}, {16'd0, sc_e});
  endtask

  initial begin
    RESET           = 1'b1;
    INSTR_BUSYWAIT  = 1'b0;
    DATA_BUSYWAIT   = 1'b0;
    REDIRECT_VALID  = 1'b0;
    REDIRECT_TARGET = 32'd0;

    // Reset, then the single BOOT cycle.
    tick("reset");
    tick("reset");
    chk_all("reset", 32'h0, 1'b0, 1'b0, 16'd0);
    RESET = 1'b0;
    tick("boot");
    chk_all("boot_exit", 32'h0, 1'b1, 1'b0, 16'd0);

    // Free run.
    tick("run");   chk_all("run1", 32'h4,  1'b1, 1'b0, 16'd0);
    tick("run");   chk_all("run2", 32'h8,  1'b1, 1'b0, 16'd0);
    tick("run");   chk_all("run3", 32'hC,  1'b1, 1'b0, 16'd0);
    tick("run");   chk_all("run4", 32'h10, 1'b1, 1'b0, 16'd0);

    // Live branch from 0x10 to 0x40.
    REDIRECT_VALID = 1'b1; REDIRECT_TARGET = 32'h40;
    tick("branch");
    chk_all("branch", 32'h40, 1'b1, 1'b0, 16'd0);
    REDIRECT_VALID = 1'b0;
    tick("run");   chk_all("branch+1", 32'h44, 1'b1, 1'b0, 16'd0);

    // Move to 0x20 for the data-stall scenario.
    REDIRECT_VALID = 1'b1; REDIRECT_TARGET = 32'h20;
    tick("jump");  chk_all("jump20", 32'h20, 1'b1, 1'b0, 16'd0);

    // Data stall for 3 cycles with a redirect to 0x80 presented throughout.
    DATA_BUSYWAIT = 1'b1; REDIRECT_VALID = 1'b1; REDIRECT_TARGET = 32'h80;
    tick("dstall");  chk_all("dstall1", 32'h20, 1'b1, 1'b0, 16'd1);
    tick("dstall");  chk_all("dstall2", 32'h20, 1'b1, 1'b0, 16'd2);
    tick("dstall");  chk_all("dstall3", 32'h20, 1'b1, 1'b0, 16'd3);
    DATA_BUSYWAIT = 1'b0; REDIRECT_VALID = 1'b0;
    tick("release"); chk_all("dstall_rel", 32'h80, 1'b1, 1'b0, 16'd3);

    // Instruction stall with a garbage redirect: must be ignored.
    INSTR_BUSYWAIT = 1'b1; REDIRECT_VALID = 1'b1; REDIRECT_TARGET = 32'h999;
    tick("istall");  chk_all("istall1", 32'h80, 1'b1, 1'b0, 16'd4);
    tick("istall");  chk_all("istall2", 32'h80, 1'b1, 1'b0, 16'd5);
    INSTR_BUSYWAIT = 1'b0; REDIRECT_VALID = 1'b0;
    tick("release"); chk_all("istall_rel", 32'h84, 1'b1, 1'b0, 16'd5);

    // Misaligned redirect near the top of the address space, then wrap.
    REDIRECT_VALID = 1'b1; REDIRECT_TARGET = 32'hFFFF_FFFE;
    tick("misalign");
    chk_all("misalign", 32'hFFFF_FFFC, 1'b1, 1'b1, 16'd5);
    REDIRECT_VALID = 1'b0;
    tick("wrap");    chk_all("wrap", 32'h0, 1'b1, 1'b1, 16'd5);
    tick("run");     chk_all("wrap+1", 32'h4, 1'b1, 1'b1, 16'd5);

    // Reset in the middle of a data stall holding a pending redirect.
    DATA_BUSYWAIT = 1'b1; REDIRECT_VALID = 1'b1; REDIRECT_TARGET = 32'h200;
    tick("dstall");  chk_all("pend1", 32'h4, 1'b1, 1'b1, 16'd6);
    tick("dstall");  chk_all("pend2", 32'h4, 1'b1, 1'b1, 16'd7);
    RESET = 1'b1;
    tick("reset");   chk_all("midreset", 32'h0, 1'b0, 1'b0, 16'd0);
    RESET = 1'b0; DATA_BUSYWAIT = 1'b0; REDIRECT_VALID = 1'b0;
    tick("boot");    chk_all("boot2_exit", 32'h0, 1'b1, 1'b0, 16'd0);
    tick("run");     chk_all("post_reset", 32'h4, 1'b1, 1'b0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
